// File: rtl/vliw_bundle_loader.sv
// Packs six 32-bit slot words into one 192-bit VLIW bundle and writes it to instruction memory.
// Optional early termination on in_last is enabled by defining VLIW_LOADER_EARLY_LAST_EN.
//
// state | meaning
// IDLE  | no session; waits for load_start
// FILL  | accepting slot words into the bundle register
// WRITE | one-cycle instruction memory write of the bundle
// FULL  | top address written; input refused until load_start
module vliw_bundle_loader #(
  parameter int SLOTS  = 6,
  parameter int SLOT_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLOT_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    imem_we,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic [SLOTS*SLOT_W-1:0] imem_wdata,
  output logic                    busy,
  output logic                    full_err,
  output logic [ADDR_W:0]         bundle_cnt
);

  localparam int IDX_W = $clog2(SLOTS);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, FULL} state_t;

  state_t                    state, state_nxt;
  logic [SLOTS*SLOT_W-1:0]   bundle, bundle_nxt;
  logic [IDX_W-1:0]          slot_idx, slot_nxt;
  logic [ADDR_W-1:0]         addr_nxt;
  logic [ADDR_W:0]           cnt_nxt;
  logic                      err_nxt;
  logic                      last_pend, last_nxt;
  logic                      last_in;

`ifdef VLIW_LOADER_EARLY_LAST_EN
  assign last_in = in_last;
`else
  logic unused_last;
  assign last_in     = 1'b0;
  assign unused_last = in_last;
`endif

  assign in_ready   = (state == FILL);
  assign busy       = (state == FILL) || (state == WRITE);
  // A reset cycle must never produce a write, even from the WRITE state.
  assign imem_we    = (state == WRITE) && !rst;
  assign imem_wdata = bundle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bundle     <= '0;
      slot_idx   <= '0;
      imem_addr  <= '0;
      bundle_cnt <= '0;
      full_err   <= 1'b0;
      last_pend  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bundle     <= bundle_nxt;
      slot_idx   <= slot_nxt;
      imem_addr  <= addr_nxt;
      bundle_cnt <= cnt_nxt;
      full_err   <= err_nxt;
      last_pend  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bundle_nxt = bundle;
    slot_nxt   = slot_idx;
    addr_nxt   = imem_addr;
    cnt_nxt    = bundle_cnt;
    err_nxt    = full_err;
    last_nxt   = last_pend;

    unique case (state)
      FILL: begin
        if (!load_start && in_valid) begin
          bundle_nxt[int'(slot_idx)*SLOT_W +: SLOT_W] = in_data;
          if (last_in) begin
            // Remaining slots become NOPs (all-zero words).
            for (int s = 0; s < SLOTS; s++) begin
              if (s > int'(slot_idx)) bundle_nxt[s*SLOT_W +: SLOT_W] = '0;
            end
          end
          if (last_in || slot_idx == IDX_W'(SLOTS-1)) begin
            state_nxt = WRITE;
            slot_nxt  = '0;
            last_nxt  = last_in;
          end else begin
            slot_nxt = slot_idx + IDX_W'(1);
          end
        end
      end
      WRITE: begin
        bundle_nxt = '0;
        cnt_nxt    = bundle_cnt + (ADDR_W+1)'(1);
        if (last_pend) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end else if (imem_addr == '1) begin
          state_nxt = FULL;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = FILL;
          addr_nxt  = imem_addr + ADDR_W'(1);
        end
      end
      default: ;
    endcase

    // A new session overrides everything; the write of a WRITE cycle still completes.
    if (load_start) begin
      state_nxt  = FILL;
      bundle_nxt = '0;
      slot_nxt   = '0;
      addr_nxt   = start_addr;
      cnt_nxt    = '0;
      err_nxt    = 1'b0;
      last_nxt   = 1'b0;
    end
  end

endmodule
